// File: rtl/big_core_cr_arb_if.sv
// Requester and CR-memory port bundle for big_core_cr_arb.
// The slave modport is the arbiter side; the master modport is the requester/memory side.
interface big_core_cr_arb_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              r0_valid, r0_ready, r0_wr, r0_lock, r0_rvalid;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata, r0_rdata;
  logic              r1_valid, r1_ready, r1_wr, r1_lock, r1_rvalid;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata, r1_rdata;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data, mem_q;
  logic              mem_wren, mem_rden;
  logic              lock_err, last_grant;

  modport slave (
    input  r0_valid, r0_wr, r0_lock, r0_addr, r0_wdata,
    input  r1_valid, r1_wr, r1_lock, r1_addr, r1_wdata,
    input  mem_q,
    output r0_ready, r0_rvalid, r0_rdata,
    output r1_ready, r1_rvalid, r1_rdata,
    output mem_address, mem_data, mem_wren, mem_rden,
    output lock_err, last_grant
  );

  modport master (
    output r0_valid, r0_wr, r0_lock, r0_addr, r0_wdata,
    output r1_valid, r1_wr, r1_lock, r1_addr, r1_wdata,
    output mem_q,
    input  r0_ready, r0_rvalid, r0_rdata,
    input  r1_ready, r1_rvalid, r1_rdata,
    input  mem_address, mem_data, mem_wren, mem_rden,
    input  lock_err, last_grant
  );
endinterface

// File: rtl/big_core_cr_arb.sv
// Round-robin two-requester arbiter for the big_core CR memory port.
// Optional grant lock with hold timeout is enabled by defining BIG_CORE_CR_ARB_LOCK_EN.
module big_core_cr_arb #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic             Clk,
  input  logic             Rst_N,
  big_core_cr_arb_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} arb_state_e;

  arb_state_e        state_q, state_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_owner_q, rd_owner_d;
  logic              last_grant_q, last_grant_d;
  logic              gnt_vld_c, gnt_idx_c, lock_err_c;
  logic              g_wr_c;
  logic [ADDR_W-1:0] g_addr_c;
  logic [DATA_W-1:0] g_wdata_c;

`ifdef BIG_CORE_CR_ARB_LOCK_EN
  localparam int unsigned CNT_W = $clog2(HOLD_MAX + 1);
  logic             g_lock_c;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign g_lock_c = gnt_idx_c ? bus.r1_lock : bus.r0_lock;
`else
  localparam int unsigned hold_max_unused = HOLD_MAX;
  logic lock_unused;
  assign lock_unused = bus.r0_lock ^ bus.r1_lock;
`endif

  assign g_wr_c    = gnt_idx_c ? bus.r1_wr    : bus.r0_wr;
  assign g_addr_c  = gnt_idx_c ? bus.r1_addr  : bus.r0_addr;
  assign g_wdata_c = gnt_idx_c ? bus.r1_wdata : bus.r0_wdata;

  // Grant selection; held off entirely while reset is asserted.
  always_comb begin
    gnt_vld_c = 1'b0;
    gnt_idx_c = 1'b0;
    unique case (state_q)
      LOCK0: gnt_vld_c = bus.r0_valid;
      LOCK1: begin
        gnt_vld_c = bus.r1_valid;
        gnt_idx_c = 1'b1;
      end
      default: begin
        gnt_vld_c = bus.r0_valid | bus.r1_valid;
        gnt_idx_c = (bus.r0_valid & bus.r1_valid) ? rr_ptr_q : bus.r1_valid;
      end
    endcase
    if (!Rst_N) gnt_vld_c = 1'b0;
  end

  // Next-state: priority rotation, read tracking and lock handling.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    rd_pend_d    = 1'b0;
    rd_owner_d   = rd_owner_q;
    last_grant_d = last_grant_q;
    lock_err_c   = 1'b0;
`ifdef BIG_CORE_CR_ARB_LOCK_EN
    cnt_d        = '0;
`endif
    if (gnt_vld_c) begin
      rr_ptr_d     = ~gnt_idx_c;
      last_grant_d = gnt_idx_c;
      rd_pend_d    = ~g_wr_c;
      rd_owner_d   = gnt_idx_c;
    end
`ifdef BIG_CORE_CR_ARB_LOCK_EN
    unique case (state_q)
      LOCK0, LOCK1: begin
        cnt_d = cnt_q + 1'b1;
        if (gnt_vld_c && !g_lock_c) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
        // Timeout overrides a renewed lock and hands priority to the other side.
        if (cnt_q == CNT_W'(HOLD_MAX - 1)) begin
          state_d    = IDLE;
          cnt_d      = '0;
          lock_err_c = 1'b1;
          rr_ptr_d   = (state_q == LOCK0);
        end
      end
      default: begin
        if (gnt_vld_c && g_lock_c) state_d = gnt_idx_c ? LOCK1 : LOCK0;
      end
    endcase
`endif
  end

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      state_q      <= IDLE;
      rr_ptr_q     <= 1'b0;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= 1'b0;
      last_grant_q <= 1'b0;
`ifdef BIG_CORE_CR_ARB_LOCK_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
      last_grant_q <= last_grant_d;
`ifdef BIG_CORE_CR_ARB_LOCK_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign bus.r0_ready    = gnt_vld_c & ~gnt_idx_c;
  assign bus.r1_ready    = gnt_vld_c & gnt_idx_c;
  assign bus.mem_wren    = gnt_vld_c & g_wr_c;
  assign bus.mem_rden    = gnt_vld_c & ~g_wr_c;
  assign bus.mem_address = gnt_vld_c ? g_addr_c : '0;
  assign bus.mem_data    = gnt_vld_c ? g_wdata_c : '0;

  // The CR memory registers q, so the response lines up with the pending read.
  assign bus.r0_rvalid   = rd_pend_q & ~rd_owner_q;
  assign bus.r1_rvalid   = rd_pend_q & rd_owner_q;
  assign bus.r0_rdata    = (rd_pend_q & ~rd_owner_q) ? bus.mem_q : '0;
  assign bus.r1_rdata    = (rd_pend_q & rd_owner_q) ? bus.mem_q : '0;
  assign bus.lock_err    = lock_err_c;
  assign bus.last_grant  = last_grant_q;
endmodule

// File: tb/tb_big_core_cr_arb.sv
// Directed bench for big_core_cr_arb: CR memory model plus a read-response scoreboard.
module tb_big_core_cr_arb;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam logic [AW-1:0] CR_LED    = 32'h0000_0010;
  localparam logic [AW-1:0] CR_SEG7_0 = 32'h0000_0020;

  typedef struct {
    int unsigned   cyc;
    bit            owner;
    logic [DW-1:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  big_core_cr_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  big_core_cr_arb #(.ADDR_W(AW), .DATA_W(DW), .HOLD_MAX(8)) dut (
    .Clk   (clk),
    .Rst_N (rst_n),
    .bus   (bus)
  );

  // CR memory: writes commit at the edge, q is registered one cycle after rden.
  logic [DW-1:0] cr_mem [16];
  always @(posedge clk) begin
    if (bus.mem_wren) cr_mem[bus.mem_address[5:2]] <= bus.mem_data;
    if (bus.mem_rden) bus.mem_q <= cr_mem[bus.mem_address[5:2]];
  end

  logic [DW-1:0] ref_mem [16];
  rsp_t          sb [$];
  int unsigned   cyc_n = 0;
  int unsigned   n_checks = 0;
  int unsigned   n_pass = 0;
  bit            exp_lg = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic drv0(input bit v, input bit wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input bit lk = 1'b0);
    bus.r0_valid = v; bus.r0_wr = wr; bus.r0_addr = a; bus.r0_wdata = d; bus.r0_lock = lk;
  endtask

  task automatic drv1(input bit v, input bit wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input bit lk = 1'b0);
    bus.r1_valid = v; bus.r1_wr = wr; bus.r1_addr = a; bus.r1_wdata = d; bus.r1_lock = lk;
  endtask

  task automatic chk_reset_outputs();
    @(negedge clk);
    chk("rst_ready",  64'({bus.r0_ready, bus.r1_ready}), 64'(0));
    chk("rst_rvalid", 64'({bus.r0_rvalid, bus.r1_rvalid}), 64'(0));
    chk("rst_rdata",  64'(bus.r0_rdata | bus.r1_rdata), 64'(0));
    chk("rst_memctl", 64'({bus.mem_wren, bus.mem_rden, bus.lock_err, bus.last_grant}), 64'(0));
    chk("rst_maddr",  64'(bus.mem_address), 64'(0));
    chk("rst_mdata",  64'(bus.mem_data), 64'(0));
  endtask

  // One cycle: check comb outputs and responses mid-cycle, update the model, advance.
  task automatic step(input bit er0, input bit er1, input bit elerr = 1'b0);
    bit            g;
    logic          gwr;
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;
    rsp_t          rsp;
    @(negedge clk);
    chk("r0_ready",   64'(bus.r0_ready), 64'(er0));
    chk("r1_ready",   64'(bus.r1_ready), 64'(er1));
    chk("lock_err",   64'(bus.lock_err), 64'(elerr));
    chk("last_grant", 64'(bus.last_grant), 64'(exp_lg));
    g   = er1;
    gwr = g ? bus.r1_wr : bus.r0_wr;
    ga  = g ? bus.r1_addr : bus.r0_addr;
    gd  = g ? bus.r1_wdata : bus.r0_wdata;
    if (er0 || er1) begin
      chk("mem_wren",    64'(bus.mem_wren), 64'(gwr));
      chk("mem_rden",    64'(bus.mem_rden), 64'(!gwr));
      chk("mem_address", 64'(bus.mem_address), 64'(ga));
      chk("mem_data",    64'(bus.mem_data), 64'(gd));
    end else begin
      chk("mem_idle_ctl",  64'({bus.mem_wren, bus.mem_rden}), 64'(0));
      chk("mem_idle_bus",  64'(bus.mem_address | bus.mem_data), 64'(0));
    end
    if (sb.size() != 0 && sb[0].cyc == cyc_n) begin
      rsp = sb.pop_front();
      chk("r0_rvalid", 64'(bus.r0_rvalid), 64'(!rsp.owner));
      chk("r1_rvalid", 64'(bus.r1_rvalid), 64'(rsp.owner));
      chk("r0_rdata",  64'(bus.r0_rdata), rsp.owner ? 64'(0) : 64'(rsp.data));
      chk("r1_rdata",  64'(bus.r1_rdata), rsp.owner ? 64'(rsp.data) : 64'(0));
    end else begin
      chk("rvalid_idle", 64'({bus.r0_rvalid, bus.r1_rvalid}), 64'(0));
      chk("rdata_idle",  64'(bus.r0_rdata | bus.r1_rdata), 64'(0));
    end
    if (er0 || er1) begin
      exp_lg = g;
      if (gwr) ref_mem[ga[5:2]] = gd;
      else sb.push_back('{cyc: cyc_n + 1, owner: g, data: ref_mem[ga[5:2]]});
    end
    @(posedge clk);
    cyc_n++;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drv0(1'b0, 1'b0, '0, '0);
    drv1(1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    drv0(1'b1, 1'b0, CR_LED, '0);
    chk_reset_outputs();
    drv0(1'b0, 1'b0, '0, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single requester traffic; seed CR_SEG7_0 from r1 first.
    drv1(1'b1, 1'b1, CR_SEG7_0, 32'h11);
    step(1'b0, 1'b1);
    drv1(1'b0, 1'b0, '0, '0);
    drv0(1'b1, 1'b1, CR_LED, 32'h2A5);
    step(1'b1, 1'b0);
    drv0(1'b1, 1'b0, CR_LED, '0);
    step(1'b1, 1'b0);
    drv0(1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0);

    // Reset while a read is in flight: response must be dropped.
    drv0(1'b1, 1'b0, CR_LED, '0);
    step(1'b1, 1'b0);
    rst_n = 1'b0;
    sb.delete();
    exp_lg = 1'b0;
    chk_reset_outputs();
    drv0(1'b0, 1'b0, '0, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 1'b0);

    // Contention: strict alternation starting from requester 0.
    drv0(1'b1, 1'b0, CR_LED, '0);
    drv1(1'b1, 1'b0, CR_SEG7_0, '0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    drv0(1'b0, 1'b0, '0, '0);
    drv1(1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0);

    // Back-to-back: r1 write then r0 read of the same register.
    drv1(1'b1, 1'b1, CR_SEG7_0, 32'h3F);
    step(1'b0, 1'b1);
    drv1(1'b0, 1'b0, '0, '0);
    drv0(1'b1, 1'b0, CR_SEG7_0, '0);
    step(1'b1, 1'b0);
    drv0(1'b1, 1'b1, CR_LED, 32'h155);
    drv1(1'b1, 1'b0, CR_LED, '0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    drv0(1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b1);
    drv1(1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0);

`ifdef BIG_CORE_CR_ARB_LOCK_EN
    // r1 lock holds r0 off until the cycle after r1's unlocked accept.
    drv0(1'b1, 1'b1, CR_LED, 32'h1);
    step(1'b1, 1'b0);
    drv0(1'b1, 1'b0, CR_LED, '0);
    drv1(1'b1, 1'b0, CR_SEG7_0, '0, 1'b1);
    step(1'b0, 1'b1);
    drv1(1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0);
    drv1(1'b1, 1'b1, CR_SEG7_0, 32'h77);
    step(1'b0, 1'b1);
    drv1(1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0);

    // Lock timeout after HOLD_MAX locked cycles, then r1 wins.
    drv0(1'b1, 1'b0, CR_LED, '0, 1'b1);
    step(1'b1, 1'b0);
    drv1(1'b1, 1'b0, CR_SEG7_0, '0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1);
    drv0(1'b0, 1'b0, '0, '0);
    drv1(1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0);
`endif

    step(1'b0, 1'b0);
    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/big_core_cr_arb.md
# big_core_cr_arb

Two-requester arbiter for the single core-side port of the big_core control-register (CR) memory. Requester 0 is the core LSU path; requester 1 is a secondary master such as a debug or fabric bridge. The block grants one transaction per cycle using round-robin priority and drives the CR memory port (`data`/`address`/`wren`/`rden`). It routes the CR memory's 1-cycle registered read data back to the requester that issued the read.

## Interface
Parameters:
- ADDR_W, 32, address width of requests and of the CR memory port.
- DATA_W, 32, write/read data width.
- HOLD_MAX, 8, maximum consecutive locked cycles before forced release (used only with the lock feature).

Ports:
- Clk  in  1  single clock.
- Rst_N  in  1  reset, asynchronous, active-low.
- r0_valid / r1_valid  in  1  request valid.
- r0_ready / r1_ready  out  1  request accepted this cycle when valid&ready.
- r0_wr / r1_wr  in  1  1 = write (store), 0 = read (load).
- r0_addr / r1_addr  in  ADDR_W  CR offset address.
- r0_wdata / r1_wdata  in  DATA_W  write data.
- r0_lock / r1_lock  in  1  request grant lock; ignored without the lock feature.
- r0_rvalid / r1_rvalid  out  1  read data valid, one-cycle pulse.
- r0_rdata / r1_rdata  out  DATA_W  read data, qualified by rvalid.
- mem_address  out  ADDR_W  to CR memory `address`.
- mem_data  out  DATA_W  to CR memory `data`.
- mem_wren  out  1  to CR memory `wren`.
- mem_rden  out  1  to CR memory `rden`.
- mem_q  in  DATA_W  from CR memory `q`; registered, valid one cycle after rden.
- lock_err  out  1  one-cycle pulse on forced lock release.
- last_grant  out  1  index of the most recently accepted requester.

## Operation
- State: rr_ptr (priority holder), rd_pend, rd_owner, last_grant, and arb_state ∈ {IDLE, LOCK0, LOCK1}.
- In IDLE, if only one requester is valid, that requester is granted. If both are valid, rr_ptr is granted. After any grant, rr_ptr becomes the non-granted index.
- ready is combinational: a requester's ready is 1 only when it is the granted requester. At most one ready is high per cycle.
- On acceptance, mem_address/mem_data are driven from the granted requester in the same cycle:
  - mem_wren = accepted & wr.
  - mem_rden = accepted & !wr.
- When no request is accepted, mem_wren = mem_rden = 0. mem_address and mem_data are then 0.
- An accepted read sets rd_pend=1 and rd_owner=grant for the next cycle. In that cycle, rX_rvalid=1 for the owner and rX_rdata=mem_q. The non-owner's rdata is 0.
- Reads and writes from either requester may be issued back-to-back every cycle. Read responses are returned in issue order.
- The arbiter does not forward data. A read issued the cycle after a write to the same address returns the new value, because the CR memory commits writes at the clock edge.
- Reset (Rst_N low, at any time) sets:
  - arb_state=IDLE, rr_ptr=0, rd_pend=0, last_grant=0.
  - All ready, rvalid, mem_wren, mem_rden and lock_err = 0; all data/address outputs = 0.
- A read in flight when reset is asserted is dropped and produces no rvalid.

## Timing
- Request-to-memory latency: 0 cycles (combinational path from valid to mem_*).
- Read latency: rvalid occurs exactly 1 cycle after acceptance.
- Write acceptance completes in 1 cycle; writes produce no response.
- Throughput: 1 transaction per cycle. Under continuous contention, grants alternate 0,1,0,1.

## Configuration
- Macro: BIG_CORE_CR_ARB_LOCK_EN.
- Defined:
  - Accepting a request with rX_lock=1 in IDLE moves to LOCKX. In LOCKX, only requester X can be granted; the other requester's ready is 0.
  - LOCKX returns to IDLE when X has an accepted request with rX_lock=0.
  - A cycle counter counts cycles spent in LOCKX. If it reaches HOLD_MAX, the next state is forced to IDLE, lock_err pulses for 1 cycle, and rr_ptr is set to the other requester.
  - The counter clears on entry to IDLE.
- Undefined: lock inputs are ignored, arb_state stays IDLE, and lock_err is tied 0.

## Test plan
- Reset mid-read: accept an r0 read of CR_LED, then drop Rst_N the next cycle -> no r0_rvalid; all outputs 0 while reset is asserted.
- Single requester: r0 writes 0x2A5 to CR_LED, then reads CR_LED -> mem_wren 1 then mem_rden 1; r0_rvalid asserted 1 cycle after the read is accepted with r0_rdata=0x2A5; r1 sees nothing.
- Contention: both requesters hold reads for 4 cycles after reset -> grants 0,1,0,1; each rvalid is routed to the correct owner; last_grant follows the grant sequence.
- Back-to-back mixed traffic: r1 writes CR_SEG7_0=0x3F, then r0 reads CR_SEG7_0 in the next cycle -> r0_rdata=0x3F.
- Lock (BIG_CORE_CR_ARB_LOCK_EN): r1 issues a locked read, then an unlocked write while r0 is valid throughout -> r0_ready stays 0 until the cycle after r1's unlocked accept.
- Lock timeout: r0 holds lock=1 with HOLD_MAX=8 -> lock_err pulses after 8 locked cycles and r1 is granted the next cycle.
